// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit
// Brief    : Execute/writeback stage around a combinational 8-bit ALU.
//            A registered issue stage reads operands from an internal
//            register file and drives the ALU. The next edge writes the
//            result back and latches the zero and carry flags.
//            Optional macro EXEC_UNIT_FWD_EN forwards the in-flight ALU
//            result to the issuing instruction. Without it the unit stalls
//            one cycle on a read-after-write hazard.
// Revision : 1.0 - initial release
// ============================================================================
module exec_unit #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic              in_use_imm,
    input  logic [7:0]        in_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    input  logic [7:0]        alu_result,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic              z_flag,
    output logic              c_flag,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [7:0]        wb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int NREG = 1 << REG_AW;

    logic [7:0]        r_regs [NREG];
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [2:0]        r_alu_op;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_valid;
    logic              r_z;
    logic              r_c;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_addr;
    logic [7:0]        r_wb_data;

    logic              w_rd_hit;
    logic              w_rs_hit;
    logic [7:0]        w_op_a;
    logic [7:0]        w_op_b;
    logic              w_ready;
    logic              w_accept;

    // Detect sources that name the register being written back at the next edge.
    always_comb begin
        w_rd_hit = r_ex_valid && (in_rd == r_ex_rd);
        w_rs_hit = r_ex_valid && !in_use_imm && (in_rs == r_ex_rd);
    end

`ifdef EXEC_UNIT_FWD_EN
    // Operand select with bypass: the in-flight ALU result replaces the stale register value.
    always_comb begin
        w_op_a  = w_rd_hit ? alu_result : r_regs[in_rd];
        w_op_b  = in_use_imm ? in_imm : (w_rs_hit ? alu_result : r_regs[in_rs]);
        w_ready = 1'b1;
    end
`else
    // Operand select without bypass: stall while a source is still being written.
    always_comb begin
        w_op_a  = r_regs[in_rd];
        w_op_b  = in_use_imm ? in_imm : r_regs[in_rs];
        w_ready = !(w_rd_hit || w_rs_hit);
    end
`endif

    assign w_accept = in_valid && w_ready;

    // Issue stage: latch ALU operands and destination on accept, otherwise hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= 8'h00;
            r_alu_b    <= 8'h00;
            r_alu_op   <= 3'b000;
            r_ex_rd    <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_alu_a  <= w_op_a;
                r_alu_b  <= w_op_b;
                r_alu_op <= in_op;
                r_ex_rd  <= in_rd;
            end
        end
    end

    // Writeback stage: flags and the writeback report follow the executing instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= 8'h00;
        end else begin
            r_wb_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_z       <= alu_z;
                r_c       <= alu_c;
                r_wb_addr <= r_ex_rd;
                r_wb_data <= alu_result;
            end
        end
    end

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            localparam logic [REG_AW-1:0] c_idx = i;
            // Register entry: written when the executing instruction targets it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[i] <= 8'h00;
                end else if (r_ex_valid && (r_ex_rd == c_idx)) begin
                    r_regs[i] <= alu_result;
                end
            end
        end
    endgenerate

    assign in_ready = w_ready;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign z_flag   = r_z;
    assign c_flag   = r_c;
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: doc/exec_unit.md
# exec_unit

Execute/writeback stage wrapped around the 8-bit ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU from a registered issue stage, then writes the ALU result back and latches the zero and carry flags. It sits between the instruction decoder (upstream) and the ALU (combinational, instantiated alongside), and closes the datapath loop.

## Interface
- REG_AW, 2, register-address width; register file holds 2**REG_AW 8-bit registers (legal 1..4)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  unit can accept this cycle
- in_op  in  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MOV)
- in_rd  in  REG_AW  destination register, also source of operand A
- in_rs  in  REG_AW  source register for operand B
- in_use_imm  in  1  1: operand B = in_imm; 0: operand B = R[in_rs]
- in_imm  in  8  immediate
- alu_a, alu_b  out  8 each  registered operands to ALU
- alu_op  out  3  registered opcode to ALU
- alu_result  in  8  ALU result
- alu_z, alu_c  in  1 each  ALU zero / carry
- z_flag, c_flag  out  1 each  architectural flags
- wb_valid  out  1  one-cycle pulse: writeback occurred on previous edge
- wb_addr  out  REG_AW  register written
- wb_data  out  8  value written
- dbg_addr  in  REG_AW  debug read address
- dbg_data  out  8  combinational R[dbg_addr]

## Operation
- Two stages: ISSUE (operand read, latch into alu_a/alu_b/alu_op, ex_rd, ex_valid) and EX/WB (ALU combinational; result written on next edge).
- Accept on edge where in_valid && in_ready. Operands: A = R[in_rd], B = in_use_imm ? in_imm : R[in_rs].
- EX/WB edge with ex_valid=1: R[ex_rd] <= alu_result; z_flag <= alu_z; c_flag <= alu_c; wb_valid <= 1, wb_addr <= ex_rd, wb_data <= alu_result. Every opcode writes rd and both flags (MOV included; ALU supplies c=0).
- No accept on an edge: ex_valid <= 0; alu_a/alu_b/alu_op hold last values; flags and registers hold.
- Register file has no reset-time special registers; all entries behave identically.
- 8-bit arithmetic throughout; no width extension inside this unit.

## Timing
- Reset (async assert): all registers 0, z_flag=0, c_flag=0, ex_valid=0, wb_valid=0, wb_addr=0, wb_data=0, alu_a=alu_b=0, alu_op=000. in_ready=1 out of reset.
- Reset asserted mid-operation: pending EX instruction discarded, no writeback, no flag update.
- Latency: accept at edge E; ALU sees operands during cycle E..E+1; register and flags updated at E+1; wb_valid high during cycle E+1..E+2; dbg_data reflects new value from E+1.
- Throughput one instruction per cycle when no stall.
- Hazard: instruction being accepted at edge E+1 reads register ex_rd written at that same edge (match on in_rd, or on in_rs when in_use_imm=0). Handling per Configuration.
- in_valid with in_ready=0: decoder holds the instruction stable; no accept.

## Configuration
- EXEC_UNIT_FWD_EN defined: bypass path; when ex_valid and a source address equals ex_rd, that operand takes alu_result instead of R[]. in_ready constant 1.
- Undefined: no bypass; in_ready = 0 in any cycle where ex_valid=1 and a source address matches ex_rd (in_rs compared only when in_use_imm=0). One-cycle bubble, then accept with the written value.
- Architectural results identical either way; only cycle counts differ.

## Test plan
- Reset: rst_n low mid-stream -> all outputs 0, in_ready=1, dbg_data 0 for every address, no wb_valid pulse.
- MOV R1,#0x80 then ADD R1,R1(rs=1) back-to-back -> R1=0x00, z_flag=1, c_flag=1; with FWD 2 accepts in 2 cycles, without FWD one bubble (in_ready=0 for 1 cycle).
- MOV R0,#0x05; MOV R2,#0x07; SUB R0,R2 -> R0=0xFE, c_flag=1, z_flag=0; wb_data sequence 05,07,FE.
- SHL R3 with R3=0x81 -> R3=0x02, c_flag=1; then SHR R3 -> R3=0x01, c_flag=0.
- in_valid gaps: single instruction then idle 5 cycles -> exactly one wb_valid pulse, flags stable, alu_* hold.
- Independent back-to-back (R0,R1,R2,R3 MOV #1..#4) with no hazard -> in_ready never drops in either configuration, 4 wb pulses on consecutive cycles.
